// File: rtl/adc_acq_sched_if.sv
// Bundle between the acquisition scheduler and its controller,
// the ADC front end and the downstream sample FIFO.
interface adc_acq_sched_if #(
    parameter int CNT_W = 16
);
    logic             start_in;
    logic             stop_in;
    logic [CNT_W-1:0] frame_num_in;
    logic [2:0]       ch_mask_in;
    logic             convert_over_in;
    logic [15:0]      dataout_in;
    logic             fifo_full_in;
    logic             adc_en_out;
    logic [1:0]       choice_out;
    logic             fifo_wr_out;
    logic [17:0]      fifo_wdata_out;
    logic             busy_out;
    logic             done_out;
    logic             timeout_err_out;
    logic             overrun_err_out;

    modport slave (
        input  start_in, stop_in, frame_num_in, ch_mask_in,
        input  convert_over_in, dataout_in, fifo_full_in,
        output adc_en_out, choice_out, fifo_wr_out, fifo_wdata_out,
        output busy_out, done_out, timeout_err_out, overrun_err_out
    );

    modport master (
        output start_in, stop_in, frame_num_in, ch_mask_in,
        output convert_over_in, dataout_in, fifo_full_in,
        input  adc_en_out, choice_out, fifo_wr_out, fifo_wdata_out,
        input  busy_out, done_out, timeout_err_out, overrun_err_out
    );
endinterface

// File: rtl/adc_acq_sched.sv
// ADC acquisition scheduler: steps the channel mux on each conversion
// event and pushes tagged samples into the DSP FIFO.
module adc_acq_sched #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 16
) (
    input logic            dsp_clk_in,
    input logic            dsp_rst_in,
    adc_acq_sched_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_CONV, SEL, CAP, DONE
    } state_t;

    state_t           state;
    logic             cv_d;
    logic             rise;
    logic [2:0]       mask;
    logic [CNT_W-1:0] fnum;
    logic [CNT_W-1:0] frame_cnt;
    logic [TW-1:0]    tcnt;
    logic             stop_seen;
    logic             adc_en;
    logic             busy;
    logic             done;
    logic             fifo_wr;
    logic [17:0]      wdata;
    logic [1:0]       choice;
    logic             t_err;
    logic             o_err;
    logic [1:0]       first_ch;
    logic [1:0]       nxt_ch;
    logic             has_nxt;
    logic             frame_last;

    assign rise = bus.convert_over_in & ~cv_d;

    // Channel walk uses the mask latched at start, never the live input
    always_comb begin
        first_ch = 2'd2;
        if (mask[0])      first_ch = 2'd0;
        else if (mask[1]) first_ch = 2'd1;
        has_nxt = ((choice == 2'd0) && (mask[1] || mask[2])) ||
                  ((choice == 2'd1) && mask[2]);
        nxt_ch  = ((choice == 2'd0) && mask[1]) ? 2'd1 : 2'd2;
        frame_last = ((fnum != '0) && (frame_cnt + CNT_W'(1) == fnum)) ||
                     stop_seen || bus.stop_in;
    end

    always_ff @(posedge dsp_clk_in) begin
        if (dsp_rst_in) begin
            state     <= IDLE;
            cv_d      <= 1'b0;
            mask      <= '0;
            fnum      <= '0;
            frame_cnt <= '0;
            tcnt      <= '0;
            stop_seen <= 1'b0;
            adc_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fifo_wr   <= 1'b0;
            wdata     <= '0;
            choice    <= '0;
            t_err     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            cv_d    <= bus.convert_over_in;
            fifo_wr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in && (bus.ch_mask_in != 3'b000)) begin
                        mask      <= bus.ch_mask_in;
                        fnum      <= bus.frame_num_in;
                        t_err     <= 1'b0;
                        o_err     <= 1'b0;
                        stop_seen <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    adc_en <= 1'b1;
                    tcnt   <= '0;
                    state  <= WAIT_CONV;
                end
                WAIT_CONV: begin
                    if (bus.stop_in) begin
                        state <= DONE;
                    end else if (rise) begin
                        choice <= first_ch;
                        state  <= SEL;
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        t_err <= 1'b1;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                SEL: begin
                    if (rise)        o_err     <= 1'b1;
                    if (bus.stop_in) stop_seen <= 1'b1;
                    state <= CAP;
                end
                CAP: begin
                    wdata   <= {choice, bus.dataout_in};
                    fifo_wr <= ~bus.fifo_full_in;
                    if (bus.fifo_full_in || rise) o_err     <= 1'b1;
                    if (bus.stop_in)              stop_seen <= 1'b1;
                    if (has_nxt) begin
                        choice <= nxt_ch;
                        state  <= SEL;
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (frame_last) begin
                            state <= DONE;
                        end else begin
                            tcnt      <= '0;
                            stop_seen <= 1'b0;
                            state     <= WAIT_CONV;
                        end
                    end
                end
                DONE: begin
                    adc_en    <= 1'b0;
                    done      <= 1'b1;
                    frame_cnt <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.adc_en_out      = adc_en;
    assign bus.choice_out      = choice;
    assign bus.fifo_wr_out     = fifo_wr;
    assign bus.fifo_wdata_out  = wdata;
    assign bus.busy_out        = busy;
    assign bus.done_out        = done;
    assign bus.timeout_err_out = t_err;
    assign bus.overrun_err_out = o_err;
endmodule

// File: tb/tb_adc_acq_sched.sv
// Directed bench for adc_acq_sched: bursts, latency, stop, timeout,
// FIFO-full drop, rise-while-busy and mid-burst reset.
module tb_adc_acq_sched;
    localparam int TO = 40;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic full_ch2 = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    int   n_done = 0;
    logic [17:0] wq[$];

    adc_acq_sched_if #(.CNT_W(CW)) bus ();

    adc_acq_sched #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .dsp_clk_in(clk),
        .dsp_rst_in(rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.dataout_in   = (bus.choice_out == 2'd0) ? 16'h1234 :
                              (bus.choice_out == 2'd1) ? 16'h5678 : 16'hABCD;
    assign bus.fifo_full_in = full_ch2 && (bus.choice_out == 2'd1);

    always @(negedge clk) begin
        if (bus.fifo_wr_out) wq.push_back(bus.fifo_wdata_out);
        if (bus.done_out) n_done++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(logic [2:0] m, logic [CW-1:0] f);
        bus.ch_mask_in   = m;
        bus.frame_num_in = f;
        bus.start_in     = 1'b1;
        tick();
        bus.start_in     = 1'b0;
    endtask

    task automatic conv_frame(int gap);
        bus.convert_over_in = 1'b1;
        tick();
        tick();
        bus.convert_over_in = 1'b0;
        repeat (gap - 2) tick();
    endtask

    int w0, d0, k;
    logic [17:0] e;

    initial begin
        bus.start_in        = 1'b0;
        bus.stop_in         = 1'b0;
        bus.frame_num_in    = '0;
        bus.ch_mask_in      = 3'b000;
        bus.convert_over_in = 1'b0;
        repeat (3) tick();
        chk("rst_adc_en", bus.adc_en_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_wr", bus.fifo_wr_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_choice", bus.choice_out, 0);
        chk("rst_errs", {bus.timeout_err_out, bus.overrun_err_out}, 0);
        rst = 1'b0;
        tick();

        // empty mask: start ignored
        start(3'b000, 1);
        tick();
        chk("m0_busy", bus.busy_out, 0);

        // T1: 3 channels, 2 frames
        w0 = wq.size();
        d0 = n_done;
        start(3'b111, 2);
        tick();
        chk("t1_adc_en", bus.adc_en_out, 1);
        chk("t1_busy", bus.busy_out, 1);
        conv_frame(12);
        conv_frame(12);
        chk("t1_nwr", wq.size() - w0, 6);
        if (wq.size() >= w0 + 6)
            for (int i = 0; i < 6; i++) begin
                e = wq[w0 + i];
                chk("t1_ch", e[17:16], i % 3);
            end
        chk("t1_done", n_done - d0, 1);
        chk("t1_adc_off", bus.adc_en_out, 0);
        chk("t1_idle", bus.busy_out, 0);

        // T2: mask 101, exact latency and data
        start(3'b101, 1);
        tick();
        bus.convert_over_in = 1'b1;
        tick();
        bus.convert_over_in = 1'b0;
        chk("t2_lat1", bus.fifo_wr_out, 0);
        tick();
        chk("t2_lat2", bus.fifo_wr_out, 0);
        tick();
        chk("t2_wr1", bus.fifo_wr_out, 1);
        chk("t2_d1", bus.fifo_wdata_out, 18'h01234);
        tick();
        chk("t2_gap", bus.fifo_wr_out, 0);
        tick();
        chk("t2_wr2", bus.fifo_wr_out, 1);
        chk("t2_d2", bus.fifo_wdata_out, 18'h2ABCD);
        tick();
        chk("t2_done", bus.done_out, 1);
        chk("t2_adc_off", bus.adc_en_out, 0);
        tick();
        chk("t2_done_1cyc", bus.done_out, 0);

        // T3: continuous, stop during CAP
        w0 = wq.size();
        d0 = n_done;
        start(3'b010, 0);
        tick();
        bus.convert_over_in = 1'b1;
        tick();
        bus.convert_over_in = 1'b0;
        tick();
        bus.stop_in = 1'b1;
        tick();
        bus.stop_in = 1'b0;
        repeat (4) tick();
        conv_frame(12);
        chk("t3_nwr", wq.size() - w0, 1);
        if (wq.size() > w0) chk("t3_data", wq[w0], 18'h15678);
        chk("t3_done", n_done - d0, 1);
        chk("t3_idle", bus.busy_out, 0);

        // T4: no conversion -> timeout
        start(3'b111, 5);
        k = 0;
        while (!bus.timeout_err_out && k < TO + 20) begin
            tick();
            k++;
        end
        chk("t4_to_cycles", k, TO + 1);
        tick();
        chk("t4_done", bus.done_out, 1);
        chk("t4_adc_off", bus.adc_en_out, 0);
        start(3'b111, 1);
        chk("t4_err_clr", bus.timeout_err_out, 0);
        tick();
        conv_frame(12);

        // T5: FIFO full while ch2 captured
        w0 = wq.size();
        full_ch2 = 1'b1;
        start(3'b111, 1);
        tick();
        conv_frame(12);
        full_ch2 = 1'b0;
        chk("t5_nwr", wq.size() - w0, 2);
        if (wq.size() >= w0 + 2) begin
            chk("t5_d1", wq[w0], 18'h01234);
            chk("t5_d3", wq[w0 + 1], 18'h2ABCD);
        end
        chk("t5_ovr", bus.overrun_err_out, 1);

        // rise while in SEL/CAP: flagged, frame unaffected
        w0 = wq.size();
        start(3'b111, 1);
        chk("t7_ovr_clr", bus.overrun_err_out, 0);
        tick();
        bus.convert_over_in = 1'b1;
        tick();
        bus.convert_over_in = 1'b0;
        tick();
        bus.convert_over_in = 1'b1;
        tick();
        bus.convert_over_in = 1'b0;
        repeat (8) tick();
        chk("t7_nwr", wq.size() - w0, 3);
        chk("t7_ovr", bus.overrun_err_out, 1);

        // T6: reset pulse in SEL
        d0 = n_done;
        start(3'b111, 1);
        tick();
        bus.convert_over_in = 1'b1;
        tick();
        bus.convert_over_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_adc_en", bus.adc_en_out, 0);
        chk("t6_busy", bus.busy_out, 0);
        chk("t6_choice", bus.choice_out, 0);
        chk("t6_wr", bus.fifo_wr_out, 0);
        chk("t6_errs", {bus.timeout_err_out, bus.overrun_err_out}, 0);
        repeat (6) tick();
        chk("t6_no_done", n_done - d0, 0);
        chk("t6_idle", bus.busy_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
